multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Main control FSM for the multi-cycle MIPS datapath; the producer side of the 4-bit alu_op bus that ALU control decodes.
//  Decodes opcode per instruction, sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath strobes, and handshakes with unified memory.
//  Also flags illegal opcodes and memory timeouts, and counts retired instructions.
// PARAMETERS
//  MEM_WAIT_MAX  15  max cycles a mem request may wait for mem_ready_i before ERROR
//  CNT_WIDTH     32  width of retired-instruction counter
// PORTS
//  clk            in   1   clock, rising edge
//  reset          in   1   asynchronous, active-low reset
//  opcode_i       in   6   IR[31:26], valid from DECODE onward
//  funct_i        in   6   IR[5:0]
//  zero_i         in   1   ALU zero flag
//  mem_ready_i    in   1   memory completes current read/write this cycle
//  alu_op_o       out  4   R=1111 ADDI=0000 ORI=0001 LUI=0010 ANDI=0011 LW=0100 SW=0101 BEQ=0110 BNE=0111 J=1000 JAL=1001
//  alu_src_a_o    out  1   0=PC, 1=rs
//  alu_src_b_o    out  2   00=rt 01=const 4 10=sign-ext imm 11=sign-ext imm<<2
//  pc_source_o    out  2   00=ALU result 01=ALUOut 10=jump target 11=rs (JR)
//  pc_write_o     out  1   unconditional PC load
//  ir_write_o     out  1   load IR
//  mem_read_o     out  1   memory read request, held until mem_ready_i
//  mem_write_o    out  1   memory write request, held until mem_ready_i
//  i_or_d_o       out  1   0=PC address, 1=ALUOut address
//  reg_write_o    out  1   register file write
//  reg_dst_o      out  2   00=rt 01=rd 10=$ra(31)
//  mem_to_reg_o   out  2   00=ALUOut 01=MDR 10=PC (JAL link)
//  instr_done_o   out  1   one-cycle pulse on instruction retire
//  error_o        out  1   sticky; set on illegal opcode or memory timeout
//  instr_count_o  out  CNT_WIDTH  retired instructions, wraps to 0
// BEHAVIOUR
//  Reset (async, any state): state=FETCH, all strobes 0, alu_op_o=0000, error_o=0, instr_count_o=0, wait counter=0.
//  Outputs are Moore, decoded from state; only pc_write_o in BRANCH is qualified by zero_i.
//  FETCH: mem_read_o=1, i_or_d_o=0, alu_src_a_o=0, alu_src_b_o=01, alu_op_o=0000.
//   When mem_ready_i=1: ir_write_o=1, pc_write_o=1 (PC+4), then DECODE. Otherwise stay in FETCH.
//  DECODE: alu_src_b_o=11, alu_op_o=0000 (branch target into ALUOut). Next state:
//   000000 -> JR if funct_i=001000, else EXEC_R
//   100011, 101011 -> MEM_ADDR
//   000100, 000101 -> BRANCH
//   000010 -> JUMP; 000011 -> JAL
//   001000, 001101, 001111, 001100 -> EXEC_I
//   any other -> ERROR
//  EXEC_R: src_a=1, src_b=00, alu_op=1111 -> WB_R: reg_dst=01, reg_write=1, done -> FETCH.
//  EXEC_I: src_a=1, src_b=10, alu_op per opcode -> WB_I: reg_dst=00, reg_write=1, done -> FETCH.
//  MEM_ADDR: src_a=1, src_b=10, alu_op=0100 (LW) / 0101 (SW) -> MEM_RD or MEM_WR.
//   MEM_RD: i_or_d=1, mem_read=1; on mem_ready_i -> WB_MEM (mem_to_reg=01, reg_write=1, done).
//   MEM_WR: i_or_d=1, mem_write=1; on mem_ready_i -> done, FETCH.
//  BRANCH: src_a=1, src_b=00, alu_op 0110/0111, pc_source=01.
//   pc_write_o=zero_i for BEQ, ~zero_i for BNE. done -> FETCH.
//  JUMP: pc_source=10, pc_write=1, alu_op=1000, done.
//  JAL: alu_op=1001, reg_dst=10, mem_to_reg=10, reg_write=1, pc_source=10, pc_write=1, done.
//  JR: alu_op=1111, pc_source=11, pc_write=1, done.
//  Latencies with zero-wait memory, FETCH to next FETCH:
//   R/I-type 4, LW 5, SW 4, BEQ/BNE/J/JAL/JR 3 cycles.
//  Wait counter: cleared on entry to FETCH/MEM_RD/MEM_WR; increments each cycle mem_ready_i=0 there.
//   Reaching MEM_WAIT_MAX -> ERROR. A mem_ready_i in that same cycle takes priority.
//  ERROR: terminal. All strobes 0, error_o=1; exit only via reset.
//  instr_done_o and instr_count_o increment coincide. Counter wraps 2^CNT_WIDTH-1 -> 0, no flag.
//  mem_read_o and mem_write_o are never both 1. Strobes never glitch across reset deassertion.
// STRUCTURE
//  Shared include mips_ctrl_defs.vh holds opcode/funct constants, the 4-bit alu_op codes and the state encodings.
//  ALU control includes the same file, so both ends agree on alu_op.
//  One sub-module: mem_wait_timer (clear, count enable, timeout flag; MEM_WAIT_MAX parameter).
// TESTING
//  1. add (op 000000, funct 100000), mem_ready_i tied 1 -> alu_op_o=1111 in EXEC_R; reg_write_o, reg_dst_o=01 in cycle 4; instr_count_o=1.
//  2. lw (100011), mem_ready_i low 3 cycles in MEM_RD -> mem_read_o held 4 cycles, WB_MEM mem_to_reg_o=01, total 8 cycles.
//  3. beq (000100) with zero_i=1, then bne (000101) with zero_i=1 -> pc_write_o=1 then 0, pc_source_o=01, alu_op_o 0110/0111.
//  4. jal (000011) -> reg_dst_o=10, mem_to_reg_o=10, alu_op_o=1001, retire in 3 cycles.
//     jr (funct 001000) -> pc_source_o=11.
//  5. Opcode 111111 -> ERROR, error_o=1, strobes 0 for 20 cycles.
//     mem_ready_i=0 in FETCH -> error after 15 cycles.
//  6. Reset asserted mid-MEM_WR -> mem_write_o=0 immediately; after release, FETCH with instr_count_o=0.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcode/funct
// constants, the 4-bit alu_op codes that ALU control decodes, state encodings
// and the decoded strobe bundle.
package multicycle_control_fsm_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [3:0] ALU_ADDI = 4'b0000;
  localparam logic [3:0] ALU_ORI  = 4'b0001;
  localparam logic [3:0] ALU_LUI  = 4'b0010;
  localparam logic [3:0] ALU_ANDI = 4'b0011;
  localparam logic [3:0] ALU_LW   = 4'b0100;
  localparam logic [3:0] ALU_SW   = 4'b0101;
  localparam logic [3:0] ALU_BEQ  = 4'b0110;
  localparam logic [3:0] ALU_BNE  = 4'b0111;
  localparam logic [3:0] ALU_J    = 4'b1000;
  localparam logic [3:0] ALU_JAL  = 4'b1001;
  localparam logic [3:0] ALU_R    = 4'b1111;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_WB_R     = 4'd3;
  localparam logic [3:0] S_EXEC_I   = 4'd4;
  localparam logic [3:0] S_WB_I     = 4'd5;
  localparam logic [3:0] S_MEM_ADDR = 4'd6;
  localparam logic [3:0] S_MEM_RD   = 4'd7;
  localparam logic [3:0] S_MEM_WR   = 4'd8;
  localparam logic [3:0] S_WB_MEM   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_JAL      = 4'd12;
  localparam logic [3:0] S_JR       = 4'd13;
  localparam logic [3:0] S_ERROR    = 4'd14;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       instr_done;
  } ctrl_t;

  // alu_op code carried by an opcode; unknown opcodes never reach a state
  // that uses it, so the default is harmless.
  function automatic logic [3:0] alu_op_for(input logic [5:0] opcode);
    logic [3:0] code;
    case (opcode)
      OP_RTYPE: code = ALU_R;
      OP_ADDI:  code = ALU_ADDI;
      OP_ORI:   code = ALU_ORI;
      OP_LUI:   code = ALU_LUI;
      OP_ANDI:  code = ALU_ANDI;
      OP_LW:    code = ALU_LW;
      OP_SW:    code = ALU_SW;
      OP_BEQ:   code = ALU_BEQ;
      OP_BNE:   code = ALU_BNE;
      OP_J:     code = ALU_J;
      OP_JAL:   code = ALU_JAL;
      default:  code = ALU_ADDI;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bus between the multi-cycle control FSM and the datapath/memory.
interface multicycle_control_fsm_if #(
  parameter int CNT_WIDTH = 32
);
  logic [5:0]           opcode_i;
  logic [5:0]           funct_i;
  logic                 zero_i;
  logic                 mem_ready_i;
  logic [3:0]           alu_op_o;
  logic                 alu_src_a_o;
  logic [1:0]           alu_src_b_o;
  logic [1:0]           pc_source_o;
  logic                 pc_write_o;
  logic                 ir_write_o;
  logic                 mem_read_o;
  logic                 mem_write_o;
  logic                 i_or_d_o;
  logic                 reg_write_o;
  logic [1:0]           reg_dst_o;
  logic [1:0]           mem_to_reg_o;
  logic                 instr_done_o;
  logic                 error_o;
  logic [CNT_WIDTH-1:0] instr_count_o;

  modport master (
    input  opcode_i, funct_i, zero_i, mem_ready_i,
    output alu_op_o, alu_src_a_o, alu_src_b_o, pc_source_o, pc_write_o,
           ir_write_o, mem_read_o, mem_write_o, i_or_d_o, reg_write_o,
           reg_dst_o, mem_to_reg_o, instr_done_o, error_o, instr_count_o
  );

  modport slave (
    output opcode_i, funct_i, zero_i, mem_ready_i,
    input  alu_op_o, alu_src_a_o, alu_src_b_o, pc_source_o, pc_write_o,
           ir_write_o, mem_read_o, mem_write_o, i_or_d_o, reg_write_o,
           reg_dst_o, mem_to_reg_o, instr_done_o, error_o, instr_count_o
  );
endinterface

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// Memory wait timer: counts stalled cycles of a pending memory request and
// flags the cycle in which the MEM_WAIT_MAX-th stall happens.
module multicycle_control_fsm_mem_wait_timer #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic timeout
);
  localparam int CW = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_WAIT_MAX - 1);

  logic [CW-1:0] count_q;

  assign timeout = count_en && (count_q == LAST);

  // Stall counter; parks on the terminal value since the FSM leaves on timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   count_q <= '0;
    else if (clear)               count_q <= '0;
    else if (count_en && !timeout) count_q <= count_q + 1'b1;
  end
endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multi-cycle MIPS datapath.
//
//  state    | meaning
//  ---------+----------------------------------------------
//  FETCH    | read instruction at PC, PC+4 on mem_ready
//  DECODE   | branch target into ALUOut, dispatch on opcode
//  EXEC_R   | R-type ALU operation
//  WB_R     | write rd, retire
//  EXEC_I   | immediate ALU operation
//  WB_I     | write rt, retire
//  MEM_ADDR | effective address for LW/SW
//  MEM_RD   | data read, waits for mem_ready
//  MEM_WR   | data write, waits for mem_ready, retire
//  WB_MEM   | write MDR to rt, retire
//  BRANCH   | BEQ/BNE compare, conditional PC load, retire
//  JUMP     | PC <- jump target, retire
//  JAL      | $ra <- PC, PC <- jump target, retire
//  JR       | PC <- rs, retire
//  ERROR    | illegal opcode or memory timeout, terminal
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_WIDTH    = 32
) (
  input logic                     clk,
  input logic                     reset,
  multicycle_control_fsm_if.master bus
);
  logic [3:0]           state_q, state_d;
  logic [3:0]           op_alu_q;
  logic                 run_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 in_wait, timeout;
  ctrl_t                ctrl;

  // run_q holds FETCH quiet for the first edge after reset so no strobe can
  // appear while reset is being released.
  assign in_wait = run_q && (state_q == S_FETCH || state_q == S_MEM_RD ||
                             state_q == S_MEM_WR);

  multicycle_control_fsm_mem_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (!in_wait || bus.mem_ready_i),
    .count_en (in_wait && !bus.mem_ready_i),
    .timeout  (timeout)
  );

  // State, run flag and the alu_op code captured at DECODE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      run_q    <= 1'b0;
      op_alu_q <= ALU_ADDI;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (state_q == S_DECODE) op_alu_q <= alu_op_for(bus.opcode_i);
    end
  end

  // Retired-instruction counter, wraps silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               count_q <= '0;
    else if (ctrl.instr_done) count_q <= count_q + 1'b1;
  end

  // Next-state logic; a mem_ready in the timeout cycle wins over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (run_q) begin
          if (bus.mem_ready_i) state_d = S_DECODE;
          else if (timeout)    state_d = S_ERROR;
        end
      end
      S_DECODE: begin
        case (bus.opcode_i)
          OP_RTYPE:                         state_d = (bus.funct_i == FN_JR) ? S_JR : S_EXEC_R;
          OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
          OP_J:                             state_d = S_JUMP;
          OP_JAL:                           state_d = S_JAL;
          OP_ADDI, OP_ORI, OP_LUI, OP_ANDI: state_d = S_EXEC_I;
          default:                          state_d = S_ERROR;
        endcase
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_ADDR: state_d = (op_alu_q == ALU_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (bus.mem_ready_i) state_d = S_WB_MEM;
        else if (timeout)    state_d = S_ERROR;
      end
      S_MEM_WR: begin
        if (bus.mem_ready_i) state_d = S_FETCH;
        else if (timeout)    state_d = S_ERROR;
      end
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
  end

  // Moore strobe decode; FETCH/MEM handshakes and BRANCH qualify on inputs.
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        if (run_q) begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = 2'b01;
          ctrl.alu_op    = ALU_ADDI;
          ctrl.ir_write  = bus.mem_ready_i;
          ctrl.pc_write  = bus.mem_ready_i;
        end
      end
      S_DECODE: ctrl.alu_src_b = 2'b11;
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_R;
      end
      S_WB_R: begin
        ctrl.reg_dst    = 2'b01;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = op_alu_q;
      end
      S_WB_I: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_RD: begin
        ctrl.i_or_d   = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.i_or_d     = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = bus.mem_ready_i;
      end
      S_WB_MEM: begin
        ctrl.mem_to_reg = 2'b01;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_op     = op_alu_q;
        ctrl.pc_source  = 2'b01;
        ctrl.pc_write   = (op_alu_q == ALU_BNE) ? !bus.zero_i : bus.zero_i;
        ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl.alu_op     = ALU_J;
        ctrl.pc_source  = 2'b10;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JAL: begin
        ctrl.alu_op     = ALU_JAL;
        ctrl.reg_dst    = 2'b10;
        ctrl.mem_to_reg = 2'b10;
        ctrl.reg_write  = 1'b1;
        ctrl.pc_source  = 2'b10;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JR: begin
        ctrl.alu_op     = ALU_R;
        ctrl.pc_source  = 2'b11;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  assign bus.alu_op_o      = ctrl.alu_op;
  assign bus.alu_src_a_o   = ctrl.alu_src_a;
  assign bus.alu_src_b_o   = ctrl.alu_src_b;
  assign bus.pc_source_o   = ctrl.pc_source;
  assign bus.pc_write_o    = ctrl.pc_write;
  assign bus.ir_write_o    = ctrl.ir_write;
  assign bus.mem_read_o    = ctrl.mem_read;
  assign bus.mem_write_o   = ctrl.mem_write;
  assign bus.i_or_d_o      = ctrl.i_or_d;
  assign bus.reg_write_o   = ctrl.reg_write;
  assign bus.reg_dst_o     = ctrl.reg_dst;
  assign bus.mem_to_reg_o  = ctrl.mem_to_reg;
  assign bus.instr_done_o  = ctrl.instr_done;
  assign bus.error_o       = (state_q == S_ERROR);
  assign bus.instr_count_o = count_q;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_fsm_if u_if ();

  multicycle_control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  typedef struct {
    string       tag;
    logic [20:0] vec;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_count = 0;

  logic [20:0] v_idle, v_err, v_frdy, v_fwait, v_dec;

  // {alu_op, src_a, src_b, pc_source, pc_write, ir_write, mem_read, mem_write,
  //  i_or_d, reg_write, reg_dst, mem_to_reg, instr_done, error}
  function automatic logic [20:0] pk(logic [3:0] alu, logic sa, logic [1:0] sb,
      logic [1:0] ps, logic pw, logic irw, logic mr, logic mw, logic iod,
      logic rw, logic [1:0] rd, logic [1:0] m2r, logic dn, logic er);
    return {alu, sa, sb, ps, pw, irw, mr, mw, iod, rw, rd, m2r, dn, er};
  endfunction

  function automatic logic [20:0] obs();
    return {u_if.alu_op_o, u_if.alu_src_a_o, u_if.alu_src_b_o, u_if.pc_source_o,
            u_if.pc_write_o, u_if.ir_write_o, u_if.mem_read_o, u_if.mem_write_o,
            u_if.i_or_d_o, u_if.reg_write_o, u_if.reg_dst_o, u_if.mem_to_reg_o,
            u_if.instr_done_o, u_if.error_o};
  endfunction

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic push(string tag, logic [20:0] v);
    exp_t e;
    e.tag = tag;
    e.vec = v;
    sb_q.push_back(e);
  endtask

  // One clock: drive inputs on the falling edge, compare shortly after.
  task automatic step(logic rdy, logic z);
    exp_t e;
    @(negedge clk);
    u_if.mem_ready_i = rdy;
    u_if.zero_i      = z;
    #1;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_empty observed=cycle expected=none");
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, {11'd0, obs()}, {11'd0, e.vec});
    end
  endtask

  task automatic chk_count(string tag);
    @(posedge clk);
    #1;
    chk(tag, u_if.instr_count_o, exp_count);
  endtask

  task automatic set_instr(logic [5:0] op, logic [5:0] fn);
    u_if.opcode_i = op;
    u_if.funct_i  = fn;
  endtask

  initial begin
    v_idle  = '0;
    v_err   = 21'd1;
    v_frdy  = pk(4'h0, 0, 2'b01, 2'b00, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    v_fwait = pk(4'h0, 0, 2'b01, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    v_dec   = pk(4'h0, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    u_if.mem_ready_i = 1'b0;
    u_if.zero_i      = 1'b0;
    set_instr(6'b000000, 6'b100000);

    #12;
    chk("reset_strobes", {11'd0, obs()}, {11'd0, v_idle});
    chk("reset_count", u_if.instr_count_o, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("release_quiet", {11'd0, obs()}, {11'd0, v_idle});

    // add, with 14 stalled fetch cycles: ready on the 15th beats the timeout
    repeat (14) push("fetch_stall", v_fwait);
    push("fetch_rdy_boundary", v_frdy);
    push("add_decode", v_dec);
    push("add_exec", pk(4'hF, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    push("add_wb", pk(4'h0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 1, 0));
    repeat (14) step(0, 0);
    repeat (4) step(1, 0);
    exp_count++;
    chk_count("add_count");

    // lw with 3 stalled read cycles
    set_instr(6'b100011, 6'b000000);
    push("lw_fetch", v_frdy);
    push("lw_decode", v_dec);
    push("lw_addr", pk(4'h4, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    repeat (4) push("lw_memrd", pk(4'h0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0));
    push("lw_wb", pk(4'h0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 1, 0));
    repeat (3) step(1, 0);
    repeat (3) step(0, 0);
    repeat (2) step(1, 0);
    exp_count++;
    chk_count("lw_count");

    // sw, zero-wait
    set_instr(6'b101011, 6'b000000);
    push("sw_fetch", v_frdy);
    push("sw_decode", v_dec);
    push("sw_addr", pk(4'h5, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    push("sw_memwr", pk(4'h0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 1, 0));
    repeat (4) step(1, 0);
    exp_count++;
    chk_count("sw_count");

    // beq taken, then bne not taken, both with zero=1
    set_instr(6'b000100, 6'b000000);
    push("beq_fetch", v_frdy);
    push("beq_decode", v_dec);
    push("beq_branch", pk(4'h6, 1, 2'b00, 2'b01, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0));
    repeat (3) step(1, 1);
    exp_count++;
    chk_count("beq_count");
    set_instr(6'b000101, 6'b000000);
    push("bne_fetch", v_frdy);
    push("bne_decode", v_dec);
    push("bne_branch", pk(4'h7, 1, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0));
    repeat (3) step(1, 1);
    exp_count++;
    chk_count("bne_count");

    // jal, jr, j
    set_instr(6'b000011, 6'b000000);
    push("jal_fetch", v_frdy);
    push("jal_decode", v_dec);
    push("jal_exec", pk(4'h9, 0, 2'b00, 2'b10, 1, 0, 0, 0, 0, 1, 2'b10, 2'b10, 1, 0));
    repeat (3) step(1, 0);
    exp_count++;
    chk_count("jal_count");
    set_instr(6'b000000, 6'b001000);
    push("jr_fetch", v_frdy);
    push("jr_decode", v_dec);
    push("jr_exec", pk(4'hF, 0, 2'b00, 2'b11, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0));
    repeat (3) step(1, 0);
    exp_count++;
    chk_count("jr_count");
    set_instr(6'b000010, 6'b000000);
    push("j_fetch", v_frdy);
    push("j_decode", v_dec);
    push("j_exec", pk(4'h8, 0, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0));
    repeat (3) step(1, 0);
    exp_count++;
    chk_count("j_count");

    // ori
    set_instr(6'b001101, 6'b000000);
    push("ori_fetch", v_frdy);
    push("ori_decode", v_dec);
    push("ori_exec", pk(4'h1, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    push("ori_wb", pk(4'h0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 1, 0));
    repeat (4) step(1, 0);
    exp_count++;
    chk_count("ori_count");

    // sw stalled in MEM_WR, reset asserted mid-write
    set_instr(6'b101011, 6'b000000);
    push("sw2_fetch", v_frdy);
    push("sw2_decode", v_dec);
    push("sw2_addr", pk(4'h5, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    repeat (2) push("sw2_memwr_wait", pk(4'h0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0));
    repeat (3) step(1, 0);
    repeat (2) step(0, 0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_memwr", {31'd0, u_if.mem_write_o}, 0);
    chk("rst_mid_strobes", {11'd0, obs()}, {11'd0, v_idle});
    exp_count = 0;
    chk("rst_mid_count", u_if.instr_count_o, exp_count);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_release_quiet", {11'd0, obs()}, {11'd0, v_idle});

    // illegal opcode: terminal ERROR with every strobe low
    set_instr(6'b111111, 6'b000000);
    push("ill_fetch", v_frdy);
    push("ill_decode", v_dec);
    repeat (20) push("ill_error", v_err);
    repeat (22) step(1, 1);
    chk_count("ill_count");

    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_from_error", {11'd0, obs()}, {11'd0, v_idle});
    @(negedge clk);
    reset = 1'b1;

    // fetch never answered: 15 stalled cycles, then ERROR
    set_instr(6'b000000, 6'b100000);
    repeat (15) push("to_fetch_wait", v_fwait);
    repeat (3) push("to_error", v_err);
    repeat (18) step(0, 0);
    chk("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
